// File: rtl/wb_harvard_arbiter.sv
// Two-master Wishbone classic arbiter: instruction-fetch and data ports of a Harvard core
// share one memory port. Transfers are serialised, with fixed or round-robin priority and a timeout abort.
module wb_harvard_arbiter #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned DATA_PRIORITY  = 1,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                      sys_clk,
   input  logic                      rst_n,
   input  logic                      i_cyc,
   input  logic                      i_stb,
   input  logic [ADDR_WIDTH-1:0]     i_addr,
   output logic [DATA_WIDTH-1:0]     i_data,
   output logic                      i_ack,
   output logic                      i_err,
   input  logic                      d_cyc,
   input  logic                      d_stb,
   input  logic                      d_we,
   input  logic [DATA_WIDTH/8-1:0]   d_sel,
   input  logic [ADDR_WIDTH-1:0]     d_addr,
   input  logic [DATA_WIDTH-1:0]     d_wdata,
   output logic [DATA_WIDTH-1:0]     d_rdata,
   output logic                      d_ack,
   output logic                      d_err,
   output logic                      core_cyc,
   output logic                      core_stb,
   output logic                      core_we,
   output logic [DATA_WIDTH/8-1:0]   core_sel,
   output logic [ADDR_WIDTH-1:0]     core_addr,
   output logic [DATA_WIDTH-1:0]     core_data_out,
   input  logic [DATA_WIDTH-1:0]     core_data_in,
   input  logic                      core_ack,
   output logic                      busy,
   output logic [1:0]                grant
);

   localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_DONE} state_t;

   state_t      state_reg;
   logic [15:0] cnt_reg;
   logic        last_data_reg;
   logic        i_req;
   logic        d_req;
   logic        pick_data;
   logic        timeout_hit;

   assign i_req       = i_cyc & i_stb;
   assign d_req       = d_cyc & d_stb;
   assign timeout_hit = TIMEOUT_EN && (cnt_reg == TIMEOUT_LAST);

   // On a tie, round-robin hands the bus to whichever master did not have it last.
   always_comb begin
      pick_data = 1'b0;
      if (d_req && !i_req)
         pick_data = 1'b1;
      else if (d_req && i_req)
         pick_data = (DATA_PRIORITY != 0) ? 1'b1 : !last_data_reg;
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         last_data_reg <= 1'b1;
         i_data        <= '0;
         i_ack         <= 1'b0;
         i_err         <= 1'b0;
         d_rdata       <= '0;
         d_ack         <= 1'b0;
         d_err         <= 1'b0;
         core_cyc      <= 1'b0;
         core_stb      <= 1'b0;
         core_we       <= 1'b0;
         core_sel      <= '0;
         core_addr     <= '0;
         core_data_out <= '0;
         busy          <= 1'b0;
         grant         <= 2'b00;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (i_req || d_req) begin
                  state_reg <= ST_BUS;
                  cnt_reg   <= '0;
                  busy      <= 1'b1;
                  core_cyc  <= 1'b1;
                  core_stb  <= 1'b1;
                  if (pick_data) begin
                     grant         <= 2'b10;
                     core_addr     <= d_addr;
                     core_sel      <= d_sel;
                     core_we       <= d_we;
                     core_data_out <= d_wdata;
                  end else begin
                     grant         <= 2'b01;
                     core_addr     <= i_addr;
                     core_sel      <= '1;
                     core_we       <= 1'b0;
                     core_data_out <= '0;
                  end
               end
            end
            ST_BUS: begin
               // Ack is tested first so it wins over a simultaneous timeout.
               if (core_ack) begin
                  state_reg <= ST_DONE;
                  core_cyc  <= 1'b0;
                  core_stb  <= 1'b0;
                  if (grant[1]) begin
                     d_rdata <= core_data_in;
                     d_ack   <= 1'b1;
                  end else begin
                     i_data  <= core_data_in;
                     i_ack   <= 1'b1;
                  end
               end else if (timeout_hit) begin
                  state_reg <= ST_DONE;
                  core_cyc  <= 1'b0;
                  core_stb  <= 1'b0;
                  if (grant[1]) begin
                     d_rdata <= '0;
                     d_err   <= 1'b1;
                  end else begin
                     i_data  <= '0;
                     i_err   <= 1'b1;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 16'd1;
               end
            end
            ST_DONE: begin
               state_reg     <= ST_IDLE;
               last_data_reg <= grant[1];
               grant         <= 2'b00;
               busy          <= 1'b0;
               i_ack         <= 1'b0;
               i_err         <= 1'b0;
               d_ack         <= 1'b0;
               d_err         <= 1'b0;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_harvard_arbiter.sv
// Randomised bench for wb_harvard_arbiter: a round-robin and a data-priority instance run in lockstep
// against a transaction-level model of arbitration, wait states and timeout.
module tb_wb_harvard_arbiter;

   localparam int TMO = 4;

   logic        sys_clk = 1'b0;
   logic        rst_n   = 1'b0;
   logic        i_cyc = 1'b0, i_stb = 1'b0;
   logic [31:0] i_addr = '0;
   logic        d_cyc = 1'b0, d_stb = 1'b0, d_we = 1'b0;
   logic [3:0]  d_sel = '0;
   logic [31:0] d_addr = '0, d_wdata = '0;
   logic [31:0] core_data_in = '0;
   logic        core_ack = 1'b0;

   logic [1:0]        core_cyc_w, core_stb_w, core_we_w, busy_w;
   logic [1:0]        i_ack_w, i_err_w, d_ack_w, d_err_w;
   logic [1:0][3:0]   core_sel_w;
   logic [1:0][31:0]  core_addr_w, core_data_out_w, i_data_w, d_rdata_w;
   logic [1:0][1:0]   grant_w;

   // Instance 0 is round-robin, instance 1 gives data priority; both share stimulus.
   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      wb_harvard_arbiter #(
         .ADDR_WIDTH(32), .DATA_WIDTH(32),
         .DATA_PRIORITY(gi), .TIMEOUT_CYCLES(TMO)
      ) dut (
         .sys_clk(sys_clk), .rst_n(rst_n),
         .i_cyc(i_cyc), .i_stb(i_stb), .i_addr(i_addr),
         .i_data(i_data_w[gi]), .i_ack(i_ack_w[gi]), .i_err(i_err_w[gi]),
         .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_sel(d_sel),
         .d_addr(d_addr), .d_wdata(d_wdata),
         .d_rdata(d_rdata_w[gi]), .d_ack(d_ack_w[gi]), .d_err(d_err_w[gi]),
         .core_cyc(core_cyc_w[gi]), .core_stb(core_stb_w[gi]), .core_we(core_we_w[gi]),
         .core_sel(core_sel_w[gi]), .core_addr(core_addr_w[gi]),
         .core_data_out(core_data_out_w[gi]),
         .core_data_in(core_data_in), .core_ack(core_ack),
         .busy(busy_w[gi]), .grant(grant_w[gi])
      );
   end

   always #5 sys_clk = ~sys_clk;

   int          n_vec = 0;
   int          n_miscompare = 0;
   int          n_xfer = 0;
   logic [31:0] exp_i_data [2];
   logic [31:0] exp_d_data [2];
   bit          last_was_d [2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscompare++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         exp_i_data[u] = '0;
         exp_d_data[u] = '0;
         last_was_d[u] = 1'b1;
      end
   endtask

   task automatic check_idle(input string where);
      for (int u = 0; u < 2; u++) begin
         check($sformatf("%s_cyc%0d", where, u),   core_cyc_w[u], 1'b0);
         check($sformatf("%s_stb%0d", where, u),   core_stb_w[u], 1'b0);
         check($sformatf("%s_busy%0d", where, u),  busy_w[u],     1'b0);
         check($sformatf("%s_grant%0d", where, u), grant_w[u],    2'b00);
         check($sformatf("%s_flags%0d", where, u),
               {i_ack_w[u], i_err_w[u], d_ack_w[u], d_err_w[u]}, 4'b0000);
         check($sformatf("%s_idata%0d", where, u), i_data_w[u],  exp_i_data[u]);
         check($sformatf("%s_drdata%0d", where, u), d_rdata_w[u], exp_d_data[u]);
      end
   endtask

   // Called at a falling edge with both DUTs in IDLE; returns at a falling edge in IDLE.
   task automatic xfer(input bit ireq, input bit dreq, input logic [31:0] ia,
                       input logic [31:0] da, input logic [3:0] ds, input bit dwe,
                       input logic [31:0] dwd, input int waits, input logic [31:0] rdat);
      bit  win_d [2];
      int  nbus;
      bit  is_ack;
      i_cyc = ireq; i_stb = ireq; i_addr = ia;
      d_cyc = dreq; d_stb = dreq; d_we = dwe; d_sel = ds; d_addr = da; d_wdata = dwd;
      core_ack     = 1'($urandom_range(0, 1));
      core_data_in = $urandom;
      n_xfer++;
      if (!ireq && !dreq) begin
         @(posedge sys_clk);
         @(negedge sys_clk);
         check_idle("noreq");
         $display("xfer %0d: no request", n_xfer);
         return;
      end
      for (int u = 0; u < 2; u++)
         win_d[u] = (ireq && dreq) ? ((u == 1) ? 1'b1 : !last_was_d[u]) : dreq;
      is_ack = (waits < TMO);
      nbus   = is_ack ? waits + 1 : TMO;
      @(posedge sys_clk);
      for (int j = 0; j < nbus; j++) begin
         @(negedge sys_clk);
         for (int u = 0; u < 2; u++) begin
            check($sformatf("bus_cyc%0d", u),   {core_cyc_w[u], core_stb_w[u], busy_w[u]}, 3'b111);
            check($sformatf("bus_grant%0d", u), grant_w[u], win_d[u] ? 2'b10 : 2'b01);
            check($sformatf("bus_addr%0d", u),  core_addr_w[u], win_d[u] ? da : ia);
            check($sformatf("bus_sel%0d", u),   core_sel_w[u], win_d[u] ? ds : 4'hF);
            check($sformatf("bus_we%0d", u),    core_we_w[u], win_d[u] ? dwe : 1'b0);
            if (win_d[u])
               check($sformatf("bus_wdata%0d", u), core_data_out_w[u], dwd);
            check($sformatf("bus_flags%0d", u),
                  {i_ack_w[u], i_err_w[u], d_ack_w[u], d_err_w[u]}, 4'b0000);
         end
         // Masters may abandon the request mid-transfer; the arbiter must not care.
         if ($urandom_range(0, 3) == 0) begin
            i_cyc = 1'b0; i_stb = 1'b0; i_addr = $urandom;
            d_cyc = 1'b0; d_stb = 1'b0; d_addr = $urandom; d_wdata = $urandom;
         end
         core_ack     = (j == waits);
         core_data_in = (j == waits) ? rdat : $urandom;
         @(posedge sys_clk);
      end
      @(negedge sys_clk);
      for (int u = 0; u < 2; u++) begin
         if (win_d[u]) exp_d_data[u] = is_ack ? rdat : 32'h0;
         else          exp_i_data[u] = is_ack ? rdat : 32'h0;
         check($sformatf("done_cyc%0d", u),   {core_cyc_w[u], core_stb_w[u]}, 2'b00);
         check($sformatf("done_busy%0d", u),  busy_w[u], 1'b1);
         check($sformatf("done_grant%0d", u), grant_w[u], win_d[u] ? 2'b10 : 2'b01);
         check($sformatf("done_flags%0d", u), {i_ack_w[u], i_err_w[u], d_ack_w[u], d_err_w[u]},
               {!win_d[u] && is_ack, !win_d[u] && !is_ack, win_d[u] && is_ack, win_d[u] && !is_ack});
         check($sformatf("done_idata%0d", u),  i_data_w[u],  exp_i_data[u]);
         check($sformatf("done_drdata%0d", u), d_rdata_w[u], exp_d_data[u]);
         last_was_d[u] = win_d[u];
      end
      // Requests and a stray ack during DONE must be ignored.
      i_cyc = 1'($urandom_range(0, 1)); i_stb = i_cyc;
      d_cyc = 1'($urandom_range(0, 1)); d_stb = d_cyc;
      core_ack = 1'($urandom_range(0, 1));
      @(posedge sys_clk);
      @(negedge sys_clk);
      check_idle("after");
      $display("xfer %0d: ireq=%0d dreq=%0d waits=%0d -> rr=%s fp=%s %s", n_xfer, ireq, dreq,
               waits, win_d[0] ? "D" : "I", win_d[1] ? "D" : "I", is_ack ? "ack" : "err");
   endtask

   task automatic reset_mid_bus();
      i_cyc = 1'b1; i_stb = 1'b1; i_addr = 32'h400;
      d_cyc = 1'b1; d_stb = 1'b1; d_addr = 32'h800; d_sel = 4'hF; d_we = 1'b1; d_wdata = 32'h1234;
      core_ack = 1'b0;
      @(posedge sys_clk);
      @(negedge sys_clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      for (int u = 0; u < 2; u++) begin
         check($sformatf("rst_strobes%0d", u),
               {core_cyc_w[u], core_stb_w[u], core_we_w[u], busy_w[u], grant_w[u]}, 6'b0);
         check($sformatf("rst_req%0d", u),
               {core_sel_w[u], core_addr_w[u], core_data_out_w[u]}, 68'h0);
         check($sformatf("rst_flags%0d", u),
               {i_ack_w[u], i_err_w[u], d_ack_w[u], d_err_w[u]}, 4'b0000);
         check($sformatf("rst_data%0d", u), {i_data_w[u], d_rdata_w[u]}, 64'h0);
      end
      i_cyc = 1'b0; i_stb = 1'b0; d_cyc = 1'b0; d_stb = 1'b0;
      core_ack = 1'b1; core_data_in = 32'hCAFEF00D;
      @(negedge sys_clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge sys_clk);
         check_idle("postrst");
      end
      core_ack = 1'b0;
      n_xfer++;
      $display("xfer %0d: reset asserted during BUS", n_xfer);
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      rst_n = 1'b1;
      #1 check_idle("reset");
      @(negedge sys_clk);

      // Continuous ties from reset: round-robin gives I, D, I, D; priority gives D every time.
      for (int k = 0; k < 4; k++)
         xfer(1, 1, 32'h1000 + 32'(k * 4), 32'h3000 + 32'(k * 4), 4'hF, 1'b0, 32'h0, 0, $urandom);
      xfer(1, 0, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, 0, 32'h00000013);
      xfer(0, 1, 32'h0, 32'h2000, 4'h3, 1'b1, 32'hDEADBEEF, 3, 32'h0BADF00D);
      xfer(0, 1, 32'h0, 32'h2004, 4'hF, 1'b0, 32'h0, 1000, 32'h0);
      xfer(1, 0, 32'h104, 32'h0, 4'h0, 1'b0, 32'h0, TMO - 1, 32'hA5A5A5A5);
      reset_mid_bus();

      for (int k = 0; k < 250; k++)
         xfer(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0), $urandom,
              $urandom, 4'($urandom), 1'($urandom_range(0, 1)), $urandom,
              $urandom_range(0, 5), $urandom);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
      $finish;
   end

endmodule
